// File: rtl/registro_entradas.sv
// registro_entradas: input register peripheral with per-bit synchronizer,
// debouncer and rising-edge flags, read over a simple processor bus.
//
// Optional feature macro: REGISTRO_ENTRADAS_IRQ_EN
//   defined   -> N_IN-bit interrupt mask (write addr 0), irq_o = reg(|(flag & mask))
//   undefined -> no mask, writes to addr 0 ignored, irq_o tied to 0
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   reg_sel_i  peripheral select
//   addr_i     0 = level register (deb), 1 = flag register
//   we_i       1 = write, 0 = read
//   wdata_i    write data (bits N_IN..31 ignored)
//   entradas_i raw asynchronous inputs
//   rdata_o    registered read data, 1-cycle latency
//   irq_o      level interrupt request
module registro_entradas #(
  parameter int unsigned N_IN            = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reg_sel_i,
  input  logic            addr_i,
  input  logic            we_i,
  input  logic [31:0]     wdata_i,
  input  logic [N_IN-1:0] entradas_i,
  output logic [31:0]     rdata_o,
  output logic            irq_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;
  logic [N_IN-1:0] r_deb;
  logic [N_IN-1:0] r_flag;
  logic [CW-1:0]   r_cnt [N_IN];
  logic [31:0]     r_rdata;

  logic [N_IN-1:0] w_deb_nxt;
  logic [CW-1:0]   w_cnt_nxt [N_IN];
  logic [N_IN-1:0] w_rise;
  logic [N_IN-1:0] w_clr;
  logic [N_IN-1:0] w_flag_nxt;
  logic            w_rd;
  logic            w_wr;
  logic            w_unused;

  assign w_rd     = reg_sel_i & ~we_i;
  assign w_wr     = reg_sel_i & we_i;
  // Upper write-data bits have no storage behind them.
  assign w_unused = ^wdata_i;

  // Debounce: count consecutive disagreeing cycles, accept at DEBOUNCE_CYCLES.
  always_comb begin
    w_deb_nxt = r_deb;
    for (int i = 0; i < N_IN; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_deb_nxt[i] = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Flags: set on debounced rise, cleared by read (all) or W1C; set wins.
  always_comb begin
    w_rise = w_deb_nxt & ~r_deb;
    w_clr  = '0;
    if (addr_i) begin
      if (w_rd)      w_clr = '1;
      else if (w_wr) w_clr = wdata_i[N_IN-1:0];
    end
    w_flag_nxt = (r_flag & ~w_clr) | w_rise;
  end

  // State registers and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_flag  <= '0;
      r_rdata <= '0;
      for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= entradas_i;
      r_sync2 <= r_sync1;
      r_deb   <= w_deb_nxt;
      r_flag  <= w_flag_nxt;
      for (int i = 0; i < N_IN; i++) r_cnt[i] <= w_cnt_nxt[i];
      if (w_rd) r_rdata <= addr_i ? 32'(r_flag) : 32'(r_deb);
    end
  end

  assign rdata_o = r_rdata;

`ifdef REGISTRO_ENTRADAS_IRQ_EN
  logic [N_IN-1:0] r_mask;
  logic            r_irq;

  // Mask register (write addr 0) and registered interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && !addr_i) r_mask <= wdata_i[N_IN-1:0];
      r_irq <= |(r_flag & r_mask);
    end
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_registro_entradas.sv
// Directed bench for registro_entradas (N_IN=8, DEBOUNCE_CYCLES=4) with a
// read-data scoreboard queue.
module tb_registro_entradas;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_sel_i;
  logic        addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [7:0]  entradas_i;
  logic [31:0] rdata_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_exp [$];

`ifdef REGISTRO_ENTRADAS_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  registro_entradas #(.N_IN(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_sel_i  (reg_sel_i),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .wdata_i    (wdata_i),
    .entradas_i (entradas_i),
    .rdata_o    (rdata_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one read; expected value goes through the scoreboard queue.
  task automatic rd(input string tag, input logic a, input logic [31:0] exp);
    logic [31:0] e;
    reg_sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    q_exp.push_back(exp);
    step(1);
    reg_sel_i = 1'b0; addr_i = 1'b0;
    if (q_exp.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard empty observed=%h expected=none", tag, rdata_o);
    end else begin
      e = q_exp.pop_front();
      check(tag, rdata_o, e);
    end
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    reg_sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    step(1);
    reg_sel_i = 1'b0; we_i = 1'b0; addr_i = 1'b0; wdata_i = '0;
  endtask

  initial begin
    reset = 1'b0; reg_sel_i = 1'b0; addr_i = 1'b0; we_i = 1'b0;
    wdata_i = '0; entradas_i = '0;
    #2;
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_irq", 32'(irq_o), 32'h0);
    step(2);
    reset = 1'b1;
    step(3);

    // Rise on bit 0: deb visible in read data the cycle after edge 6.
    entradas_i = 8'h01;
    for (int k = 0; k < 7; k++) rd("rise0_latency", 1'b0, (k == 6) ? 32'h1 : 32'h0);
    step(3);
    rd("rise0_level", 1'b0, 32'h0000_0001);
    rd("rise0_flag", 1'b1, 32'h0000_0001);

    // Falling edge sets no flag.
    entradas_i = 8'h00;
    step(8);
    rd("fall0_flag", 1'b1, 32'h0);
    rd("fall0_level", 1'b0, 32'h0);

    // Glitch of 3 cycles on bit 3 is rejected.
    entradas_i = 8'h08;
    step(3);
    entradas_i = 8'h00;
    step(8);
    rd("glitch3_level", 1'b0, 32'h0);
    rd("glitch3_flag", 1'b1, 32'h0);

    // Rise on bit 5, clear-on-read.
    entradas_i = 8'h20;
    step(8);
    rd("rise5_flag", 1'b1, 32'h0000_0020);
    rd("rise5_flag_cleared", 1'b1, 32'h0);

    // W1C: upper wdata bits ignored, bit 1 cleared.
    entradas_i = 8'h23;
    step(8);
    wr(1'b1, 32'hFFFF_FF00);
    wr(1'b1, 32'h0000_0002);
    rd("w1c_flags", 1'b1, 32'h0000_0001);

    // W1C of bit 1 in the same cycle bit 1 sets: set wins.
    entradas_i = 8'h20;
    step(8);
    entradas_i = 8'h21;
    step(8);
    entradas_i = 8'h23;
    step(5);
    wr(1'b1, 32'h0000_0002);
    rd("w1c_set_prio", 1'b1, 32'h0000_0003);

    // Clear-on-read in the same cycle bit 1 sets: pre-clear value read, set wins.
    entradas_i = 8'h21;
    step(8);
    entradas_i = 8'h23;
    step(5);
    rd("rd_set_prio_ret", 1'b1, 32'h0);
    rd("rd_set_prio_flag", 1'b1, 32'h0000_0002);

    // Interrupt mask: bit 2 enabled, bit 1 not.
    entradas_i = 8'h20;
    step(8);
    rd("irq_pre_flags", 1'b1, 32'h0);
    wr(1'b0, 32'h0000_0004);
    entradas_i = 8'h22;
    step(8);
    check("irq_masked_bit1", 32'(irq_o), 32'h0);
    rd("irq_bit1_flag", 1'b1, 32'h0000_0002);
    entradas_i = 8'h26;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      check("irq_rise_bit2", 32'(irq_o), (IRQ_EN && k == 7) ? 32'h1 : 32'h0);
    end
    rd("irq_bit2_flag", 1'b1, 32'h0000_0004);
    check("irq_at_clear", 32'(irq_o), IRQ_EN ? 32'h1 : 32'h0);
    step(1);
    check("irq_after_clear", 32'(irq_o), 32'h0);
    rd("addr0_write_no_effect", 1'b0, 32'h0000_0026);

    // Asynchronous reset mid-count, then steady 8'hFF accepted in 6 cycles.
    entradas_i = 8'hFF;
    step(3);
    reset = 1'b0;
    #1;
    check("async_rst_rdata", rdata_o, 32'h0);
    check("async_rst_irq", 32'(irq_o), 32'h0);
    step(2);
    reset = 1'b1;
    for (int k = 0; k < 7; k++) rd("post_rst_latency", 1'b0, (k == 6) ? 32'hFF : 32'h0);
    rd("post_rst_flags", 1'b1, 32'h0000_00FF);
    check("post_rst_irq_mask_clear", 32'(irq_o), 32'h0);

    if (q_exp.size() != 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q_exp.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
